// File: rtl/program_counter_unit_if.sv
// Fetch-path bus between the sequencing logic (master) and the program
// counter (slave). The jump request pair only exists when PC_JUMP_EN is
// defined; the default build carries the sequential-advance signals only.
interface program_counter_unit_if #(
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] read_addr;
    logic              done;
    logic              halt;
`ifdef PC_JUMP_EN
    logic              jump_en;
    logic [ADDR_W-1:0] jump_addr;
`endif
    logic [ADDR_W-1:0] output_read_addr;
    logic              wrap;

    // Side that issues completion/halt/jump and consumes the next address.
    modport master (
        output read_addr, done, halt,
`ifdef PC_JUMP_EN
        output jump_en, jump_addr,
`endif
        input  output_read_addr, wrap
    );

    // Program counter side.
    modport slave (
        input  read_addr, done, halt,
`ifdef PC_JUMP_EN
        input  jump_en, jump_addr,
`endif
        output output_read_addr, wrap
    );
endinterface

// File: rtl/program_counter_unit.sv
// Program counter for the fetch path. Produces the registered next fetch
// address from the address currently executing: advances to read_addr + 1
// when the instruction completes, otherwise holds. halt freezes the PC and
// beats every other request. The optional load (jump) path is compiled in
// when the macro PC_JUMP_EN is defined; it ranks below halt and above done.
module program_counter_unit #(
    parameter int ADDR_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    program_counter_unit_if.slave bus
);

    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] pc_next;
    logic              wrap_reg;
    logic              wrap_next;
    // One extra bit so the carry out of the increment marks a rollover.
    logic [ADDR_W:0]   inc_sum;

    assign inc_sum = {1'b0, bus.read_addr} + {{ADDR_W{1'b0}}, 1'b1};

    // Next-state selection in priority order: halt, jump, done, hold.
    always_comb begin
        pc_next   = pc_reg;
        wrap_next = 1'b0;
        if (bus.halt) begin
            pc_next   = pc_reg;
            wrap_next = 1'b0;
        end
`ifdef PC_JUMP_EN
        else if (bus.jump_en) begin
            pc_next   = bus.jump_addr;
            wrap_next = 1'b0;
        end
`endif
        else if (bus.done) begin
            // Increment is based on read_addr, so a held done settles
            // instead of running the PC forward every cycle.
            pc_next   = inc_sum[ADDR_W-1:0];
            wrap_next = inc_sum[ADDR_W];
        end
    end

    // State register; reset forces address 0 and clears the wrap pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg   <= '0;
            wrap_reg <= 1'b0;
        end else begin
            pc_reg   <= pc_next;
            wrap_reg <= wrap_next;
        end
    end

    assign bus.output_read_addr = pc_reg;
    assign bus.wrap             = wrap_reg;

endmodule

// File: tb/tb_program_counter_unit.sv
// Bench for program_counter_unit: reset checks, a table of directed vectors,
// hand sequences for jump (when PC_JUMP_EN is defined), then randomized
// stimulus checked against an arithmetic reference model.
module tb_program_counter_unit;

    localparam int AW    = 6;
    localparam int DEPTH = 1 << AW;

    logic clk;
    logic rst;

    program_counter_unit_if #(.ADDR_W(AW)) pc_bus ();

    program_counter_unit #(.ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (pc_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int ra;
        bit done;
        bit halt;
        int exp_pc;
        bit exp_wrap;
        string name;
    } vec_t;

    vec_t tbl[16];
    int   n_vec;

    // Reference model state.
    int pc_m;
    bit wrap_m;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic drive(input int ra, input bit d, input bit h);
        pc_bus.read_addr = ra[AW-1:0];
        pc_bus.done      = d;
        pc_bus.halt      = h;
`ifdef PC_JUMP_EN
        pc_bus.jump_en   = 1'b0;
        pc_bus.jump_addr = '0;
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input string nm, input int ra, input bit d, input bit h,
                           input int epc, input bit ew);
        tbl[n_vec].name     = nm;
        tbl[n_vec].ra       = ra;
        tbl[n_vec].done     = d;
        tbl[n_vec].halt     = h;
        tbl[n_vec].exp_pc   = epc;
        tbl[n_vec].exp_wrap = ew;
        n_vec++;
    endtask

    // Behavioural model: one clock of the program counter from the rules.
    task automatic model_step(input int ra, input bit d, input bit h,
                              input bit jen, input int ja);
        if (h) begin
            wrap_m = 1'b0;
        end else if (jen) begin
            pc_m   = ja;
            wrap_m = 1'b0;
        end else if (d) begin
            wrap_m = ((ra + 1) == DEPTH);
            pc_m   = (ra + 1) % DEPTH;
        end else begin
            wrap_m = 1'b0;
        end
    endtask

    initial begin
        n_vec = 0;
        add_vec("adv1",      1, 1, 0,  2, 0);
        add_vec("adv3",      3, 1, 0,  4, 0);
        add_vec("adv1b",     1, 1, 0,  2, 0);
        add_vec("hold2",     2, 0, 0,  2, 0);
        add_vec("hold9",     9, 0, 0,  2, 0);
        add_vec("wrap63",   63, 1, 0,  0, 1);
        add_vec("wraphold",  5, 0, 0,  0, 0);
        add_vec("halt10",   10, 1, 1,  0, 0);
        add_vec("unhalt10", 10, 1, 0, 11, 0);
        add_vec("wrapA",    63, 1, 0,  0, 1);
        add_vec("wrapB",    63, 1, 0,  0, 1);
        add_vec("settleA",  20, 1, 0, 21, 0);
        add_vec("settleB",  20, 1, 0, 21, 0);
        add_vec("haltwrap", 63, 1, 1, 21, 0);

        // Reset asserted with an advance pending.
        rst = 1'b1;
        drive(5, 1, 0);
        #2;
        check("rst_pc", int'(pc_bus.output_read_addr), 0);
        check("rst_wrap", int'(pc_bus.wrap), 0);
        step();
        step();
        check("rst_hold_pc", int'(pc_bus.output_read_addr), 0);
        check("rst_hold_wrap", int'(pc_bus.wrap), 0);
        $display("reset: pc=%0d wrap=%0d", pc_bus.output_read_addr, pc_bus.wrap);
        rst = 1'b0;
        step();
        check("post_rst_adv", int'(pc_bus.output_read_addr), 6);
        $display("release: ra=5 done=1 -> pc=%0d", pc_bus.output_read_addr);

        // Asynchronous reset between edges, with a nonzero PC.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_pc", int'(pc_bus.output_read_addr), 0);
        $display("async reset mid-cycle: pc=%0d", pc_bus.output_read_addr);
        @(negedge clk);
        rst = 1'b0;

        // Directed vector table.
        for (int i = 0; i < n_vec; i++) begin
            drive(tbl[i].ra, tbl[i].done, tbl[i].halt);
            step();
            check({tbl[i].name, "_pc"}, int'(pc_bus.output_read_addr), tbl[i].exp_pc);
            check({tbl[i].name, "_wrap"}, int'(pc_bus.wrap), int'(tbl[i].exp_wrap));
            $display("vec %s: ra=%0d done=%0d halt=%0d -> pc=%0d wrap=%0d",
                     tbl[i].name, tbl[i].ra, tbl[i].done, tbl[i].halt,
                     pc_bus.output_read_addr, pc_bus.wrap);
        end

`ifdef PC_JUMP_EN
        // Jump beats done.
        drive(7, 1, 0);
        pc_bus.jump_en   = 1'b1;
        pc_bus.jump_addr = 6'd40;
        step();
        check("jump_pc", int'(pc_bus.output_read_addr), 40);
        check("jump_wrap", int'(pc_bus.wrap), 0);
        $display("jump: ja=40 ra=7 done=1 -> pc=%0d", pc_bus.output_read_addr);
        // Halt beats jump.
        drive(7, 1, 1);
        pc_bus.jump_en   = 1'b1;
        pc_bus.jump_addr = 6'd12;
        step();
        check("halt_jump_pc", int'(pc_bus.output_read_addr), 40);
        $display("halt+jump: -> pc=%0d", pc_bus.output_read_addr);
        // Jump with read_addr at top must not report a wrap.
        drive(63, 1, 0);
        pc_bus.jump_en   = 1'b1;
        pc_bus.jump_addr = 6'd3;
        step();
        check("jump_top_pc", int'(pc_bus.output_read_addr), 3);
        check("jump_top_wrap", int'(pc_bus.wrap), 0);
        $display("jump over top: -> pc=%0d wrap=%0d", pc_bus.output_read_addr, pc_bus.wrap);
`endif

        // Randomized phase from a known starting point.
        drive(30, 1, 0);
        step();
        pc_m   = 31;
        wrap_m = 1'b0;
        check("rand_seed_pc", int'(pc_bus.output_read_addr), pc_m);
        for (int i = 0; i < 300; i++) begin
            int ra;
            bit d, h, jen;
            int ja;
            ra  = int'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 3) == 0) ra = DEPTH - 1;
            d   = ($urandom_range(0, 3) != 0);
            h   = ($urandom_range(0, 7) == 0);
            jen = 1'b0;
            ja  = int'($urandom_range(0, DEPTH - 1));
            drive(ra, d, h);
`ifdef PC_JUMP_EN
            jen = ($urandom_range(0, 5) == 0);
            pc_bus.jump_en   = jen;
            pc_bus.jump_addr = ja[AW-1:0];
`endif
            model_step(ra, d, h, jen, ja);
            step();
            check("rand_pc", int'(pc_bus.output_read_addr), pc_m);
            check("rand_wrap", int'(pc_bus.wrap), int'(wrap_m));
            $display("rand %0d: ra=%0d done=%0d halt=%0d jump=%0d -> pc=%0d wrap=%0d",
                     i, ra, d, h, jen, pc_bus.output_read_addr, pc_bus.wrap);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
